inc_seq_gen: RTL and testbench

Incrementing address/sequence generator for the arithmetic library. It accepts a command (base value, beat count) over a valid/ready handshake and emits the stream base, base+1, …, base+len-1 over a second valid/ready handshake. Values wrap modulo 2^width. It is the sequential stage directly downstream of the incrementer: it registers the current value and uses `IncC` (CI=1) as its next-value logic, taking `IncC`'s CO as the wrap indication.

---
 rtl/inc_seq_gen.sv | 151 +++++++++++++++
 tb/tb_inc_seq_gen.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/inc_seq_gen.sv
// Incrementing sequence generator: takes (base, len) commands and streams
// base, base+1, ..., base+len-1 (mod 2^width) with a wrap flag per beat.
// Also holds the shared speed-selection package and the IncC incrementer
// that provides the next-value arithmetic.

package lau_pkg;
    typedef enum logic [0:0] {
        SLOW = 1'b0,
        FAST = 1'b1
    } speed_e;
endpackage

// Incrementer Z = A + CI with carry-out. SLOW builds an explicit ripple
// chain, FAST leaves the adder structure to the synthesis tool.
module IncC #(
    parameter int              width = 8,
    parameter lau_pkg::speed_e speed = lau_pkg::FAST
) (
    input  logic [width-1:0] A,
    input  logic             CI,
    output logic [width-1:0] Z,
    output logic             CO
);
    generate
        if (speed == lau_pkg::SLOW) begin : g_ripple
            logic [width:0] carry;
            assign carry[0] = CI;
            for (genvar gi = 0; gi < width; gi++) begin : g_bit
                assign Z[gi]         = A[gi] ^ carry[gi];
                assign carry[gi + 1] = A[gi] & carry[gi];
            end
            assign CO = carry[width];
        end else begin : g_fast
            assign {CO, Z} = {1'b0, A} + (width + 1)'(CI);
        end
    endgenerate
endmodule

module inc_seq_gen #(
    parameter int              width    = 8,
    parameter int              lenWidth = 8,
    parameter lau_pkg::speed_e speed    = lau_pkg::FAST
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [width-1:0]    cmd_base_i,
    input  logic [lenWidth-1:0] cmd_len_i,
    input  logic                cmd_valid_i,
    output logic                cmd_ready_o,
    output logic [width-1:0]    out_data_o,
    output logic                out_wrap_o,
    output logic                out_last_o,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic                busy_o
);
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t              state_reg, state_next;
    logic [width-1:0]    cur_reg, cur_next;
    logic [lenWidth-1:0] rem_reg, rem_next;
    logic                wrap_reg, wrap_next;

    logic [width-1:0]    inc_z;
    logic                inc_co;
    logic                run;
    logic                last;
    logic                cmd_fire;
    logic                beat_fire;
    logic                cmd_nonzero;

    // Next value of the sequence; the carry-out marks the all-ones -> zero step.
    IncC #(
        .width(width),
        .speed(speed)
    ) u_inc (
        .A (cur_reg),
        .CI(1'b1),
        .Z (inc_z),
        .CO(inc_co)
    );

    assign run         = (state_reg == RUN);
    assign last        = run && (rem_reg == '0);
    assign cmd_nonzero = (cmd_len_i != '0);

    // Ready to take a command when idle, or when the final beat leaves this
    // cycle (combinational on out_ready_i so commands chain with no bubble).
    assign cmd_ready_o = !run || (last && out_ready_i);
    assign cmd_fire    = cmd_valid_i && cmd_ready_o;
    assign beat_fire   = run && out_ready_i;

    // Outputs come straight from registers; nothing from cmd_* reaches out_*.
    assign out_valid_o = run;
    assign out_data_o  = cur_reg;
    assign out_wrap_o  = run && wrap_reg;
    assign out_last_o  = last;
    assign busy_o      = run;

    // Next-state and datapath: load on command, step on a non-final beat.
    always_comb begin
        state_next = state_reg;
        cur_next   = cur_reg;
        rem_next   = rem_reg;
        wrap_next  = wrap_reg;
        unique case (state_reg)
            IDLE: begin
                if (cmd_fire && cmd_nonzero) begin
                    cur_next   = cmd_base_i;
                    rem_next   = cmd_len_i - lenWidth'(1);
                    wrap_next  = 1'b0;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (beat_fire) begin
                    if (!last) begin
                        cur_next  = inc_z;
                        wrap_next = inc_co;
                        rem_next  = rem_reg - lenWidth'(1);
                    end else if (cmd_fire && cmd_nonzero) begin
                        cur_next  = cmd_base_i;
                        rem_next  = cmd_len_i - lenWidth'(1);
                        wrap_next = 1'b0;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State and datapath registers; reset abandons any command at once.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg <= IDLE;
            cur_reg   <= '0;
            rem_reg   <= '0;
            wrap_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            cur_reg   <= cur_next;
            rem_reg   <= rem_next;
            wrap_reg  <= wrap_next;
        end
    end
endmodule

// File: tb/tb_inc_seq_gen.sv
// Directed testbench for inc_seq_gen (width=8, lenWidth=8).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_inc_seq_gen;
    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic [7:0] cmd_base_i;
    logic [7:0] cmd_len_i;
    logic       cmd_valid_i;
    logic       cmd_ready_o;
    logic [7:0] out_data_o;
    logic       out_wrap_o;
    logic       out_last_o;
    logic       out_valid_o;
    logic       out_ready_i;
    logic       busy_o;

    int n_pass  = 0;
    int n_total = 0;

    inc_seq_gen #(
        .width   (8),
        .lenWidth(8),
        .speed   (lau_pkg::FAST)
    ) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .cmd_base_i (cmd_base_i),
        .cmd_len_i  (cmd_len_i),
        .cmd_valid_i(cmd_valid_i),
        .cmd_ready_o(cmd_ready_o),
        .out_data_o (out_data_o),
        .out_wrap_o (out_wrap_o),
        .out_last_o (out_last_o),
        .out_valid_o(out_valid_o),
        .out_ready_i(out_ready_i),
        .busy_o     (busy_o)
    );

    always #5 clk_i = ~clk_i;

    // Observed vector layout: {cmd_ready, busy, valid, data[7:0], wrap, last}
    logic [12:0] obs;
    assign obs = {cmd_ready_o, busy_o, out_valid_o, out_data_o, out_wrap_o, out_last_o};

    // Present one command for a single cycle; returns at the next falling edge.
    task automatic issue_cmd(input logic [7:0] base, input logic [7:0] len);
        cmd_base_i  = base;
        cmd_len_i   = len;
        cmd_valid_i = 1'b1;
        @(negedge clk_i);
        cmd_valid_i = 1'b0;
        $display("cmd base=%02h len=%0d", base, len);
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        @(negedge clk_i);
        n_total++;
        if (obs !== 13'b1_0_0_00000000_0_0)
            $display("FAIL reset_state: got %b expected %b", obs, 13'b1_0_0_00000000_0_0);
        else n_pass++;
        rst_ni = 1'b1;
        @(negedge clk_i);
        n_total++;
        if (obs !== 13'b1_0_0_00000000_0_0)
            $display("FAIL after_release: got %b expected %b", obs, 13'b1_0_0_00000000_0_0);
        else n_pass++;
    endtask

    task automatic test_basic();
        logic [12:0] exp_v [3];
        exp_v[0] = {1'b0, 1'b1, 1'b1, 8'h05, 1'b0, 1'b0};
        exp_v[1] = {1'b0, 1'b1, 1'b1, 8'h06, 1'b0, 1'b0};
        exp_v[2] = {1'b1, 1'b1, 1'b1, 8'h07, 1'b0, 1'b1};
        out_ready_i = 1'b1;
        issue_cmd(8'h05, 8'd3);
        for (int i = 0; i < 3; i++) begin
            $display("basic beat %0d data=%02h wrap=%b last=%b", i, out_data_o, out_wrap_o, out_last_o);
            n_total++;
            if (obs !== exp_v[i])
                $display("FAIL basic_beat%0d: got %b expected %b", i, obs, exp_v[i]);
            else n_pass++;
            @(negedge clk_i);
        end
        n_total++;
        if (obs[11:10] !== 2'b00)
            $display("FAIL basic_idle: busy/valid got %b expected 00", obs[11:10]);
        else n_pass++;
    endtask

    task automatic test_wrap();
        logic [12:0] exp_v [4];
        exp_v[0] = {1'b0, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0};
        exp_v[1] = {1'b0, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0};
        exp_v[2] = {1'b0, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0};
        exp_v[3] = {1'b1, 1'b1, 1'b1, 8'h01, 1'b0, 1'b1};
        out_ready_i = 1'b1;
        issue_cmd(8'hFE, 8'd4);
        for (int i = 0; i < 4; i++) begin
            $display("wrap beat %0d data=%02h wrap=%b last=%b", i, out_data_o, out_wrap_o, out_last_o);
            n_total++;
            if (obs !== exp_v[i])
                $display("FAIL wrap_beat%0d: got %b expected %b", i, obs, exp_v[i]);
            else n_pass++;
            @(negedge clk_i);
        end
        n_total++;
        if (obs[11:10] !== 2'b00)
            $display("FAIL wrap_idle: busy/valid got %b expected 00", obs[11:10]);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        out_ready_i = 1'b0;
        issue_cmd(8'h10, 8'd2);
        for (int i = 0; i < 3; i++) begin
            $display("stall cycle %0d data=%02h valid=%b", i, out_data_o, out_valid_o);
            n_total++;
            if (obs !== {1'b0, 1'b1, 1'b1, 8'h10, 1'b0, 1'b0})
                $display("FAIL stall%0d: got %b expected %b", i, obs, {1'b0, 1'b1, 1'b1, 8'h10, 1'b0, 1'b0});
            else n_pass++;
            @(negedge clk_i);
        end
        out_ready_i = 1'b1;
        #1;
        n_total++;
        if (obs !== {1'b0, 1'b1, 1'b1, 8'h10, 1'b0, 1'b0})
            $display("FAIL bp_release: got %b expected %b", obs, {1'b0, 1'b1, 1'b1, 8'h10, 1'b0, 1'b0});
        else n_pass++;
        @(negedge clk_i);
        $display("bp beat data=%02h last=%b", out_data_o, out_last_o);
        n_total++;
        if (obs !== {1'b1, 1'b1, 1'b1, 8'h11, 1'b0, 1'b1})
            $display("FAIL bp_second: got %b expected %b", obs, {1'b1, 1'b1, 1'b1, 8'h11, 1'b0, 1'b1});
        else n_pass++;
        @(negedge clk_i);
        n_total++;
        if (obs[11:10] !== 2'b00)
            $display("FAIL bp_idle: busy/valid got %b expected 00", obs[11:10]);
        else n_pass++;
    endtask

    task automatic test_zero_len();
        out_ready_i = 1'b1;
        issue_cmd(8'h33, 8'd0);
        for (int i = 0; i < 2; i++) begin
            n_total++;
            if ({cmd_ready_o, busy_o, out_valid_o} !== 3'b100)
                $display("FAIL zero_len%0d: ready/busy/valid got %b expected 100", i,
                         {cmd_ready_o, busy_o, out_valid_o});
            else n_pass++;
            @(negedge clk_i);
        end
    endtask

    task automatic test_back_to_back();
        out_ready_i = 1'b1;
        issue_cmd(8'h20, 8'd2);
        n_total++;
        if (obs !== {1'b0, 1'b1, 1'b1, 8'h20, 1'b0, 1'b0})
            $display("FAIL b2b_beat0: got %b expected %b", obs, {1'b0, 1'b1, 1'b1, 8'h20, 1'b0, 1'b0});
        else n_pass++;
        @(negedge clk_i);
        n_total++;
        if (obs !== {1'b1, 1'b1, 1'b1, 8'h21, 1'b0, 1'b1})
            $display("FAIL b2b_beat1: got %b expected %b", obs, {1'b1, 1'b1, 1'b1, 8'h21, 1'b0, 1'b1});
        else n_pass++;
        issue_cmd(8'h80, 8'd1);
        $display("b2b beat data=%02h last=%b", out_data_o, out_last_o);
        n_total++;
        if (obs !== {1'b1, 1'b1, 1'b1, 8'h80, 1'b0, 1'b1})
            $display("FAIL b2b_beat2: got %b expected %b", obs, {1'b1, 1'b1, 1'b1, 8'h80, 1'b0, 1'b1});
        else n_pass++;
        @(negedge clk_i);
        n_total++;
        if (obs[11:10] !== 2'b00)
            $display("FAIL b2b_idle: busy/valid got %b expected 00", obs[11:10]);
        else n_pass++;
    endtask

    task automatic test_reset_mid_run();
        out_ready_i = 1'b1;
        issue_cmd(8'h00, 8'd255);
        for (int i = 0; i < 100; i++) @(negedge clk_i);
        n_total++;
        if (obs !== {1'b0, 1'b1, 1'b1, 8'd100, 1'b0, 1'b0})
            $display("FAIL mid_beat100: got %b expected %b", obs, {1'b0, 1'b1, 1'b1, 8'd100, 1'b0, 1'b0});
        else n_pass++;
        #2 rst_ni = 1'b0;
        #1;
        $display("async reset asserted mid-run");
        n_total++;
        if (obs !== 13'b1_0_0_00000000_0_0)
            $display("FAIL async_reset: got %b expected %b", obs, 13'b1_0_0_00000000_0_0);
        else n_pass++;
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        n_total++;
        if (obs[11:10] !== 2'b00)
            $display("FAIL post_reset_idle: busy/valid got %b expected 00", obs[11:10]);
        else n_pass++;
        issue_cmd(8'h03, 8'd1);
        n_total++;
        if (obs !== {1'b1, 1'b1, 1'b1, 8'h03, 1'b0, 1'b1})
            $display("FAIL post_reset_beat: got %b expected %b", obs, {1'b1, 1'b1, 1'b1, 8'h03, 1'b0, 1'b1});
        else n_pass++;
        @(negedge clk_i);
        n_total++;
        if (obs[11:10] !== 2'b00)
            $display("FAIL post_reset_done: busy/valid got %b expected 00", obs[11:10]);
        else n_pass++;
    endtask

    task automatic test_max_len();
        logic [12:0] exp_v;
        out_ready_i = 1'b1;
        issue_cmd(8'h00, 8'd255);
        for (int i = 0; i < 255; i++) begin
            exp_v = {(i == 254), 1'b1, 1'b1, 8'(i), 1'b0, (i == 254)};
            $display("max beat %0d data=%02h last=%b", i, out_data_o, out_last_o);
            n_total++;
            if (obs !== exp_v)
                $display("FAIL max_beat%0d: got %b expected %b", i, obs, exp_v);
            else n_pass++;
            @(negedge clk_i);
        end
        n_total++;
        if (obs[11:10] !== 2'b00)
            $display("FAIL max_idle: busy/valid got %b expected 00", obs[11:10]);
        else n_pass++;
    endtask

    initial begin
        rst_ni      = 1'b0;
        cmd_base_i  = '0;
        cmd_len_i   = '0;
        cmd_valid_i = 1'b0;
        out_ready_i = 1'b0;
        test_reset();
        test_basic();
        test_wrap();
        test_backpressure();
        test_zero_len();
        test_back_to_back();
        test_reset_mid_run();
        test_max_len();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
